of_action_writer: RTL and testbench

Producer side of the action bus consumed by the OpenFlow action processor. It snoops the packet stream entering the processor, pairs each packet with one lookup result from the flow matcher, and emits exactly one action word per packet. Actions carry either a set-output-port command or a no-op, and are issued in packet order. Issue is gated by a credit counter that mirrors the processor's action FIFO, so that FIFO can never overflow.

---
 rtl/of_action_writer_pkg.sv | 25 ++
 rtl/of_action_writer.sv | 157 +++++++++++++++
 tb/tb_of_action_writer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/of_action_writer_pkg.sv
// Shared constants for the action bus between the writer and the OpenFlow
// action processor, plus the writer's state encoding.
package of_action_writer_pkg;

  // Action bus geometry
  localparam int OF_ACTION_DATA_W = 64;
  localparam int OF_ACTION_CTRL_W = 8;

  // Destination-port field inside the action data word
  localparam int OF_DST_PORT_W   = 16;
  localparam int OF_DST_PORT_POS = 0;

  // Ctrl bit that tells the action processor to rewrite the output port
  localparam int OF_ACTION_SET_PORT_BIT = 0;

  // Ctrl value that marks the module-header word opening each packet
  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_RESULT = 2'd1,
    ST_ISSUE       = 2'd2
  } state_e;

endpackage

// File: rtl/of_action_writer.sv
// Pairs every snooped packet with one flow-matcher result and writes one
// action word per packet to the action processor, in packet order. A credit
// counter mirrors the processor's action FIFO so it can never overflow.
module of_action_writer
  import of_action_writer_pkg::*;
#(
  parameter int DATA_WIDTH           = 64,
  parameter int CTRL_WIDTH           = DATA_WIDTH / 8,
  parameter int OF_ACTION_DATA_WIDTH = OF_ACTION_DATA_W,
  parameter int OF_ACTION_CTRL_WIDTH = OF_ACTION_CTRL_W,
  parameter int ACTION_FIFO_DEPTH    = 4,
  parameter int PENDING_WIDTH        = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [CTRL_WIDTH-1:0]           in_ctrl,
  input  logic                            in_wr,
  input  logic                            lookup_valid,
  output logic                            lookup_rdy,
  input  logic                            lookup_hit,
  input  logic [15:0]                     lookup_port,
  input  logic [15:0]                     default_port,
  input  logic                            action_rd,
  output logic [OF_ACTION_DATA_WIDTH-1:0] action_data_bus,
  output logic [OF_ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
  output logic                            action_valid,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count,
  output logic                            protocol_err
);

  localparam int CREDIT_WIDTH = $clog2(ACTION_FIFO_DEPTH + 1);
  localparam logic [CREDIT_WIDTH-1:0] CREDITS_FULL = CREDIT_WIDTH'(ACTION_FIFO_DEPTH);

  state_e                          state_q;
  logic [PENDING_WIDTH-1:0]        pending_q, pending_d;
  logic [CREDIT_WIDTH-1:0]         credits_q, credits_d;
  logic [OF_ACTION_DATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [OF_ACTION_CTRL_WIDTH-1:0] act_ctrl_q, act_ctrl_d;
  logic [OF_ACTION_DATA_WIDTH-1:0] bus_data_q;
  logic [OF_ACTION_CTRL_WIDTH-1:0] bus_ctrl_q;
  logic                            valid_q;
  logic [31:0]                     hit_q, miss_q;
  logic                            err_q;
  logic                            pkt_start;
  logic                            issue;
  logic                            pend_ovf;
  logic                            rd_err;

  // Packet payload is not needed; only the start-of-packet marker matters.
  logic unused_in_data;
  assign unused_in_data = ^in_data;

  assign pkt_start  = in_wr && (in_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
  assign issue      = (state_q == ST_ISSUE) && (credits_q != '0);
  assign lookup_rdy = (state_q == ST_WAIT_RESULT);

  // Pending-packet up/down counter; saturates and flags on overflow.
  always_comb begin
    pending_d = pending_q;
    pend_ovf  = 1'b0;
    if (pkt_start && !issue) begin
      if (pending_q == '1) pend_ovf = 1'b1;
      else                 pending_d = pending_q + 1'b1;
    end else if (!pkt_start && issue) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // Credit up/down counter mirroring free slots in the consumer FIFO.
  // A pop while the mirror says "empty" is a consumer protocol error.
  always_comb begin
    credits_d = credits_q;
    rd_err    = action_rd && (credits_q == CREDITS_FULL);
    if (valid_q && !action_rd) begin
      credits_d = credits_q - 1'b1;
    end else if (action_rd && !valid_q && (credits_q != CREDITS_FULL)) begin
      credits_d = credits_q + 1'b1;
    end
  end

  // Form the action word from the current matcher result.
  always_comb begin
    act_data_d = '0;
    act_ctrl_d = '0;
    if (lookup_hit) begin
      act_ctrl_d[OF_ACTION_SET_PORT_BIT]                = 1'b1;
      act_data_d[OF_DST_PORT_POS +: OF_DST_PORT_W]      = lookup_port;
    end else if (default_port != 16'd0) begin
      act_ctrl_d[OF_ACTION_SET_PORT_BIT]                = 1'b1;
      act_data_d[OF_DST_PORT_POS +: OF_DST_PORT_W]      = default_port;
    end
  end

  // Counter and sticky-error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      credits_q <= CREDITS_FULL;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      credits_q <= credits_d;
      if (pend_ovf || rd_err) err_q <= 1'b1;
    end
  end

  // Issue FSM with registered action outputs and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      act_data_q <= '0;
      act_ctrl_q <= '0;
      bus_data_q <= '0;
      bus_ctrl_q <= '0;
      valid_q    <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      valid_q    <= 1'b0;
      bus_data_q <= '0;
      bus_ctrl_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pending_q != '0) state_q <= ST_WAIT_RESULT;
        end
        ST_WAIT_RESULT: begin
          if (lookup_valid) begin
            act_data_q <= act_data_d;
            act_ctrl_q <= act_ctrl_d;
            if (lookup_hit) hit_q  <= hit_q + 32'd1;
            else            miss_q <= miss_q + 32'd1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (credits_q != '0) begin
            valid_q    <= 1'b1;
            bus_data_q <= act_data_q;
            bus_ctrl_q <= act_ctrl_q;
            state_q    <= (pending_d != '0) ? ST_WAIT_RESULT : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign action_valid    = valid_q;
  assign action_data_bus = bus_data_q;
  assign action_ctrl_bus = bus_ctrl_q;
  assign hit_count       = hit_q;
  assign miss_count      = miss_q;
  assign protocol_err    = err_q;

endmodule

// File: tb/tb_of_action_writer.sv
// Directed bench for of_action_writer: latency, hit/miss forming, credit
// stall and release, held lookups, credit corner cases, reset and overflow.
module tb_of_action_writer;
  import of_action_writer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        lookup_valid = 1'b0;
  logic        lookup_rdy;
  logic        lookup_hit = 1'b0;
  logic [15:0] lookup_port = '0;
  logic [15:0] default_port = '0;
  logic        action_rd = 1'b0;
  logic [63:0] action_data_bus;
  logic [7:0]  action_ctrl_bus;
  logic        action_valid;
  logic [31:0] hit_count, miss_count;
  logic        protocol_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;

  logic [15:0] obs_port [0:63];
  int          obs_n = 0;
  int          base;

  of_action_writer dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .lookup_valid(lookup_valid), .lookup_rdy(lookup_rdy),
    .lookup_hit(lookup_hit), .lookup_port(lookup_port),
    .default_port(default_port), .action_rd(action_rd),
    .action_data_bus(action_data_bus), .action_ctrl_bus(action_ctrl_bus),
    .action_valid(action_valid), .hit_count(hit_count),
    .miss_count(miss_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Record the port of every issued action in order.
  always @(negedge clk) begin
    if (action_valid) begin
      obs_port[obs_n[5:0]] = action_data_bus[15:0];
      obs_n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pkt_start();
    in_wr   = 1'b1;
    in_ctrl = 8'hff;
    in_data = {$urandom, $urandom};
    step();
    in_wr   = 1'b0;
    in_ctrl = 8'h00;
  endtask

  task automatic pop();
    action_rd = 1'b1;
    step();
    action_rd = 1'b0;
  endtask

  // Present a result and hold it until accepted; returns one cycle after the handshake.
  task automatic handshake(input logic hit, input logic [15:0] port);
    bit done = 1'b0;
    lookup_valid = 1'b1;
    lookup_hit   = hit;
    lookup_port  = port;
    for (int i = 0; i < 20 && !done; i++) begin
      if (lookup_rdy) done = 1'b1;
      step();
    end
    lookup_valid = 1'b0;
    check("handshake_done", 64'(done), 64'd1);
  endtask

  // Wait for the next action pulse; returns on the cycle it is high.
  task automatic expect_action(input string tag, input logic [15:0] port, input logic [7:0] ctrl);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (action_valid) seen = 1'b1;
      else step();
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_data"}, action_data_bus, {48'h0, port});
    check({tag, "_ctrl"}, 64'(action_ctrl_bus), 64'(ctrl));
  endtask

  initial begin
    @(negedge clk);
    step();
    // Reset values
    check("rst_rdy", 64'(lookup_rdy), 64'd0);
    check("rst_valid", 64'(action_valid), 64'd0);
    check("rst_data", action_data_bus, 64'd0);
    check("rst_ctrl", 64'(action_ctrl_bus), 64'd0);
    check("rst_hits", 64'(hit_count), 64'd0);
    check("rst_miss", 64'(miss_count), 64'd0);
    check("rst_err", 64'(protocol_err), 64'd0);
    check("rst_credits", 64'(dut.credits_q), 64'd4);
    check("rst_pending", 64'(dut.pending_q), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset = 1'b0;
    step();

    // Single hit: exact latency from packet start and from handshake
    default_port = 16'h0009;
    pkt_start();
    check("t1_pending", 64'(dut.pending_q), 64'd1);
    check("t1_rdy_early", 64'(lookup_rdy), 64'd0);
    handshake(1'b1, 16'h0004);
    check("t1_valid_n1", 64'(action_valid), 64'd0);
    check("t1_data_idle", action_data_bus, 64'd0);
    check("t1_hits", 64'(hit_count), 64'd1);
    step();
    check("t1_valid_n2", 64'(action_valid), 64'd1);
    check("t1_data", action_data_bus, 64'h4);
    check("t1_ctrl", 64'(action_ctrl_bus), 64'h1);
    step();
    check("t1_valid_off", 64'(action_valid), 64'd0);
    check("t1_credits", 64'(dut.credits_q), 64'd3);
    pop();

    // Misses: with default port, then no-op
    default_port = 16'h0001;
    pkt_start();
    handshake(1'b0, 16'hbeef);
    expect_action("t2_dflt", 16'h0001, 8'h01);
    step();
    pop();
    default_port = 16'h0000;
    pkt_start();
    handshake(1'b0, 16'h1234);
    expect_action("t2_noop", 16'h0000, 8'h00);
    step();
    pop();
    check("t2_miss", 64'(miss_count), 64'd2);
    check("t2_hits", 64'(hit_count), 64'd1);
    check("t2_credits", 64'(dut.credits_q), 64'd4);

    // Six back-to-back packets: four actions, stall, release with two pops
    default_port = 16'h0001;
    base = obs_n;
    in_wr = 1'b1;
    in_ctrl = 8'hff;
    repeat (6) step();
    in_wr = 1'b0;
    in_ctrl = 8'h00;
    check("t3_pending6", 64'(dut.pending_q), 64'd6);
    for (int i = 0; i < 5; i++) handshake(1'b1, 16'(16'h10 + i));
    repeat (8) step();
    check("t3_count4", 64'(obs_n - base), 64'd4);
    check("t3_stall_state", 64'(dut.state_q), 64'(ST_ISSUE));
    check("t3_pending2", 64'(dut.pending_q), 64'd2);
    check("t3_credits0", 64'(dut.credits_q), 64'd0);
    check("t3_rdy_stall", 64'(lookup_rdy), 64'd0);
    pop();
    pop();
    handshake(1'b1, 16'h0015);
    repeat (8) step();
    check("t3_count6", 64'(obs_n - base), 64'd6);
    for (int i = 0; i < 6; i++) check("t3_order", 64'(obs_port[base + i]), 64'(16'h10 + i));
    check("t3_pending0", 64'(dut.pending_q), 64'd0);
    check("t3_idle", 64'(dut.state_q), 64'(ST_IDLE));
    repeat (4) pop();
    check("t3_credits4", 64'(dut.credits_q), 64'd4);

    // Held lookup with nothing pending is ignored, then consumed by the next packet
    base = obs_n;
    lookup_valid = 1'b1;
    lookup_hit   = 1'b1;
    lookup_port  = 16'h0042;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_rdy_low", 64'(lookup_rdy), 64'd0);
      check("t4_no_action", 64'(action_valid), 64'd0);
    end
    pkt_start();
    handshake(1'b1, 16'h0042);
    expect_action("t4_held", 16'h0042, 8'h01);
    step();
    pop();
    check("t4_one_action", 64'(obs_n - base), 64'd1);
    check("t4_hits", 64'(hit_count), 64'd8);

    // Simultaneous pop and write; then pop with full credits
    pkt_start();
    handshake(1'b1, 16'h0050);
    expect_action("t5_a", 16'h0050, 8'h01);
    step();
    check("t5_credits3", 64'(dut.credits_q), 64'd3);
    pkt_start();
    handshake(1'b1, 16'h0051);
    expect_action("t5_b", 16'h0051, 8'h01);
    pop();
    check("t5_same_cycle", 64'(dut.credits_q), 64'd3);
    check("t5_err_clean", 64'(protocol_err), 64'd0);
    pop();
    check("t5_credits4", 64'(dut.credits_q), 64'd4);
    check("t5_err_still0", 64'(protocol_err), 64'd0);
    pop();
    check("t5_err_set", 64'(protocol_err), 64'd1);
    check("t5_credits_sat", 64'(dut.credits_q), 64'd4);
    repeat (3) step();
    check("t5_err_sticky", 64'(protocol_err), 64'd1);

    // Reset while stalled in ISSUE with no credits
    for (int i = 0; i < 4; i++) begin
      pkt_start();
      handshake(1'b1, 16'(16'h60 + i));
      expect_action("t6_fill", 16'(16'h60 + i), 8'h01);
      step();
    end
    pkt_start();
    handshake(1'b1, 16'h0064);
    step();
    check("t6_stall_state", 64'(dut.state_q), 64'(ST_ISSUE));
    check("t6_credits0", 64'(dut.credits_q), 64'd0);
    base = obs_n;
    reset = 1'b1;
    step();
    check("t6_valid", 64'(action_valid), 64'd0);
    check("t6_data", action_data_bus, 64'd0);
    check("t6_ctrl", 64'(action_ctrl_bus), 64'd0);
    check("t6_rdy", 64'(lookup_rdy), 64'd0);
    check("t6_hits", 64'(hit_count), 64'd0);
    check("t6_miss", 64'(miss_count), 64'd0);
    check("t6_err", 64'(protocol_err), 64'd0);
    check("t6_credits", 64'(dut.credits_q), 64'd4);
    check("t6_pending", 64'(dut.pending_q), 64'd0);
    check("t6_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset = 1'b0;
    repeat (4) step();
    check("t6_no_partial", 64'(obs_n - base), 64'd0);

    // Pending counter saturation
    in_wr = 1'b1;
    in_ctrl = 8'hff;
    repeat (255) step();
    check("t7_pending_max", 64'(dut.pending_q), 64'd255);
    check("t7_err_before", 64'(protocol_err), 64'd0);
    step();
    in_wr = 1'b0;
    in_ctrl = 8'h00;
    check("t7_pending_sat", 64'(dut.pending_q), 64'd255);
    check("t7_err_ovf", 64'(protocol_err), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
